// File: rtl/credit_link_pkg.sv
// Shared definitions for the credit-based transmit link.
//   BEAT_CNT_W     : width of the in-burst beat index carried with each beat
//   credit_width() : counter width able to hold 0..max credits
//   next_beat_cnt(): beat index after launching a beat (wraps, clears on last)
package credit_link_pkg;

    localparam int BEAT_CNT_W = 4;

    function automatic int credit_width(input int max);
        return $clog2(max) + 1;
    endfunction

    function automatic logic [BEAT_CNT_W-1:0] next_beat_cnt(
        input logic [BEAT_CNT_W-1:0] cnt,
        input logic                  last
    );
        return last ? '0 : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter for the transmit side of a credit link.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (credits reload to MAX_CREDITS)
//   consume   : one credit spent this cycle (only asserted while nonzero)
//   ret       : credits returned this cycle, amount in ret_cnt
//   ret_cnt   : number of credits returned (ignored when ret=0)
//   credits   : current credit count
//   nonzero   : credits != 0, registered-path so launch never sees a same-cycle return
//   overflow  : sticky, a return would have pushed the count above MAX_CREDITS
module credit_counter
    import credit_link_pkg::*;
#(
    parameter int MAX_CREDITS = 8,
    localparam int CW = credit_width(MAX_CREDITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          consume,
    input  logic          ret,
    input  logic [CW-1:0] ret_cnt,
    output logic [CW-1:0] credits,
    output logic          nonzero,
    output logic          overflow
);

    localparam logic [CW:0]   MAX_EXT  = (CW + 1)'(MAX_CREDITS);
    localparam logic [CW-1:0] MAX_INIT = CW'(MAX_CREDITS);

    logic [CW-1:0] credits_reg;
    logic [CW-1:0] credits_next;
    logic          overflow_reg;
    logic          overflow_next;
    logic [CW:0]   sum;

    // One extra bit so an oversized return is visible before saturation.
    always_comb begin
        sum           = {1'b0, credits_reg} - {{CW{1'b0}}, consume}
                        + (ret ? {1'b0, ret_cnt} : '0);
        credits_next  = sum[CW-1:0];
        overflow_next = overflow_reg;
        if (sum > MAX_EXT) begin
            credits_next  = MAX_INIT;
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_reg  <= MAX_INIT;
            overflow_reg <= 1'b0;
        end else begin
            credits_reg  <= credits_next;
            overflow_reg <= overflow_next;
        end
    end

    assign credits  = credits_reg;
    assign nonzero  = (credits_reg != '0);
    assign overflow = overflow_reg;

endmodule

// File: rtl/credit_tx_bridge.sv
// Bridges a valid/ready stream (with last framing) onto a credit-based
// transmit link. A main/skid register pair keeps s_ready a pure flop output;
// one beat launches per cycle whenever a credit is held.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : upstream stream (s_ready registered)
//   tx_valid/tx_data/tx_last      : launched beat, no back-pressure, costs one credit
//   tx_beat_count           : index of the launched beat inside its burst
//   credit_return/credits_returned : credits handed back by the receiver
//   credits                 : current credit count
//   credit_overflow         : sticky, receiver returned more than it was given
module credit_tx_bridge
    import credit_link_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_CREDITS = 8,
    localparam int CW = credit_width(MAX_CREDITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_last,
    output logic [BEAT_CNT_W-1:0] tx_beat_count,
    input  logic                  credit_return,
    input  logic [CW-1:0]         credits_returned,
    output logic [CW-1:0]         credits,
    output logic                  credit_overflow
);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t                 main_reg, main_next;
    beat_t                 skid_reg, skid_next;
    logic                  main_valid_reg, main_valid_next;
    logic                  skid_valid_reg, skid_valid_next;
    logic                  s_ready_reg;
    logic [BEAT_CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic  launch;
    logic  accept;
    logic  credits_nonzero;
    beat_t in_beat;

    assign in_beat = '{last: s_last, data: s_data};
    assign launch  = main_valid_reg && credits_nonzero;
    assign accept  = s_valid && s_ready_reg;

    credit_counter #(
        .MAX_CREDITS (MAX_CREDITS)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .consume  (launch),
        .ret      (credit_return),
        .ret_cnt  (credits_returned),
        .credits  (credits),
        .nonzero  (credits_nonzero),
        .overflow (credit_overflow)
    );

    // Skid pair. s_ready is low whenever the skid is occupied, so a full
    // skid never coincides with an accept.
    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (skid_valid_reg) begin
            if (launch) begin
                main_next       = skid_reg;
                skid_valid_next = 1'b0;
            end
        end else if (!main_valid_reg || launch) begin
            // Main is free this cycle: a new beat goes straight in (pass-through).
            main_valid_next = accept;
            if (accept) begin
                main_next = in_beat;
            end
        end else if (accept) begin
            skid_next       = in_beat;
            skid_valid_next = 1'b1;
        end
    end

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (launch) begin
            beat_cnt_next = next_beat_cnt(beat_cnt_reg, main_reg.last);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            s_ready_reg    <= 1'b1;
            beat_cnt_reg   <= '0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            s_ready_reg    <= !skid_valid_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    // Outputs come from flops only; no combinational path from s_* to tx_*.
    assign s_ready       = s_ready_reg;
    assign tx_valid      = launch;
    assign tx_data       = main_reg.data;
    assign tx_last       = main_reg.last;
    assign tx_beat_count = beat_cnt_reg;

endmodule

// File: tb/tb_credit_tx_bridge.sv
module tb_credit_tx_bridge;

    localparam int DW = 32;
    localparam int MC = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic [3:0]    tx_beat_count;
    logic          credit_return;
    logic [CW-1:0] credits_returned;
    logic [CW-1:0] credits;
    logic          credit_overflow;

    credit_tx_bridge #(
        .DATA_WIDTH  (DW),
        .MAX_CREDITS (MC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_last           (s_last),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_last          (tx_last),
        .tx_beat_count    (tx_beat_count),
        .credit_return    (credit_return),
        .credits_returned (credits_returned),
        .credits          (credits),
        .credit_overflow  (credit_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [3:0]    cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         errors   = 0;
    int         checks   = 0;
    int         tx_count = 0;
    logic [3:0] exp_pos  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, wait (bounded) for it to be accepted, then record the
    // beat the link should eventually carry.
    task automatic send(input logic [DW-1:0] data, input logic last);
        logic rdy;
        int   n;
        exp_t e;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        n       = 0;
        do begin
            rdy = s_ready;
            tick();
            n++;
        end while (!rdy && n < 100);
        s_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: data 0x%0h not accepted, got ready=0 expected ready=1", data);
        end else begin
            e.data = data;
            e.last = last;
            e.cnt  = exp_pos;
            exp_q.push_back(e);
            exp_pos = last ? 4'd0 : exp_pos + 4'd1;
            $display("accept data=0x%0h last=%0d pos=%0d", data, last, e.cnt);
        end
    endtask

    task automatic ret(input logic [CW-1:0] n);
        credit_return    = 1'b1;
        credits_returned = n;
        tick();
        credit_return    = 1'b0;
        credits_returned = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_pos = '0;
    endtask

    // Scoreboard monitor: every launched beat must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx_valid === 1'b1) begin
                tx_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got data 0x%0h expected no launch", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("tx data=0x%0h last=%0d count=%0d", tx_data, tx_last, tx_beat_count);
                    chk("tx_data", tx_data, e.data);
                    chk("tx_last", 32'(tx_last), 32'(e.last));
                    chk("tx_beat_count", 32'(tx_beat_count), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        s_valid          = 1'b0;
        s_data           = '0;
        s_last           = 1'b0;
        credit_return    = 1'b0;
        credits_returned = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_credits", 32'(credits), 8);
        chk("rst_overflow", 32'(credit_overflow), 0);
        chk("rst_beat_count", 32'(tx_beat_count), 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_last", 32'(tx_last), 0);

        // 8-beat burst, no returns: back-to-back launches, credits run out
        for (int i = 1; i <= 8; i++) send(DW'(i), i == 8);
        chk("stream_tx_count_mid", tx_count, 7);
        chk("stream_credits_mid", 32'(credits), 1);
        tick();
        chk("stream_tx_count", tx_count, 8);
        chk("stream_credits_empty", 32'(credits), 0);
        chk("stream_tx_idle", 32'(tx_valid), 0);

        // Zero credits: main+skid fill, upstream stalls, returns release in order
        fork
            begin
                send(32'h11, 1'b0);
                send(32'h12, 1'b0);
                send(32'h13, 1'b1);
            end
            begin
                tick(); tick(); tick();
                chk("stall_s_ready", 32'(s_ready), 0);
                chk("stall_tx_valid", 32'(tx_valid), 0);
                ret(4'd2);
                chk("ret2_credits", 32'(credits), 2);
                tick();
                chk("ret2_s_ready", 32'(s_ready), 1);
                chk("ret2_credits_after1", 32'(credits), 1);
                tick();
                chk("ret2_credits_spent", 32'(credits), 0);
                chk("ret2_third_held", 32'(tx_valid), 0);
                tick();
                chk("third_still_held", 32'(tx_valid), 0);
                chk("ret2_tx_count", tx_count, 10);
                ret(4'd1);
                chk("third_launch", 32'(tx_valid), 1);
                tick();
                chk("third_credits", 32'(credits), 0);
                chk("third_tx_count", tx_count, 11);
            end
        join

        // credits=1: launch and return of 1 in the same cycle
        ret(4'd1);
        send(32'h21, 1'b0);
        credit_return    = 1'b1;
        credits_returned = 4'd1;
        send(32'h22, 1'b1);
        credit_return    = 1'b0;
        credits_returned = '0;
        chk("c1_credits_kept", 32'(credits), 1);
        chk("c1_launch_again", 32'(tx_valid), 1);
        tick();
        chk("c1_credits_after", 32'(credits), 0);
        chk("c1_tx_count", tx_count, 13);

        // Over-return: 7 + 3 saturates at 8, overflow sticks
        ret(4'd7);
        chk("ret7_credits", 32'(credits), 7);
        chk("ret7_overflow", 32'(credit_overflow), 0);
        ret(4'd3);
        chk("sat_credits", 32'(credits), 8);
        chk("sat_overflow", 32'(credit_overflow), 1);

        // 20-beat burst with a credit returned every cycle: beat index wraps
        fork
            for (int i = 0; i < 20; i++) send(DW'(i), i == 19);
            begin
                repeat (25) begin
                    credit_return    = 1'b1;
                    credits_returned = 4'd1;
                    tick();
                end
                credit_return    = 1'b0;
                credits_returned = '0;
            end
        join
        repeat (4) tick();
        chk("burst_drained", exp_q.size(), 0);
        chk("burst_tx_count", tx_count, 33);
        chk("burst_overflow_sticky", 32'(credit_overflow), 1);
        chk("burst_beat_count_end", 32'(tx_beat_count), 0);

        // Drain credits, fill main+skid, return 3, then reset mid-operation
        for (int i = 0; i < 8; i++) send(32'h30 + DW'(i), i == 7);
        tick();
        tick();
        chk("drain_credits", 32'(credits), 0);
        chk("drain_tx_count", tx_count, 41);
        send(32'h40, 1'b0);
        send(32'h41, 1'b0);
        chk("full_s_ready", 32'(s_ready), 0);
        chk("full_tx_valid", 32'(tx_valid), 0);
        ret(4'd3);
        chk("full_credits3", 32'(credits), 3);
        do_reset();
        chk("mid_rst_tx_valid", 32'(tx_valid), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 1);
        chk("mid_rst_credits", 32'(credits), 8);
        chk("mid_rst_beat_count", 32'(tx_beat_count), 0);
        chk("mid_rst_overflow", 32'(credit_overflow), 0);
        chk("mid_rst_tx_data", tx_data, 0);
        repeat (5) tick();
        chk("mid_rst_no_emit", tx_count, 41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
